// File: rtl/inst_fetch.sv
// inst_fetch: IF stage; samples pc_reg's PC, runs the imem req/ack handshake, loads IF/ID.
// Latency: IDLE->REQ one edge, IF/ID loads on the ack edge (1 instr / 2 cycles at zero wait).
// Backpressure: stallreq_if holds the pipeline until data; stall[1] parks the word in HOLD.
// Optional macro IF_ALIGN_CHECK_EN: misaligned PCs skip memory and deliver an adel-flagged NOP.
module inst_fetch #(
  parameter logic [31:0] NOP_INST       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        ce_i,
  input  logic [5:0]  stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_adel_o,
  output logic        stallreq_if,
  output logic        fetch_timeout_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

  logic [1:0]  state_q, state_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic        timeout_q, timeout_d;
  logic        data_avail;
  logic        waiting;
`ifdef IF_ALIGN_CHECK_EN
  logic        adel_pend_q, adel_pend_d;
  logic        id_adel_q, id_adel_d;
`endif

  // Only the IF/ID hold and ID hold bits matter to this stage.
  logic unused_stall_bits;
  assign unused_stall_bits = ^{stall[5:3], stall[0]};

  assign waiting    = (state_q == S_REQ) || (state_q == S_DROP);
  assign data_avail = ((state_q == S_REQ) && imem_ack) || (state_q == S_HOLD);
  // DROP keeps ctrl stalled even if pc_reg withdraws ce_i.
  assign stallreq_if = (ce_i && !data_avail) || (state_q == S_DROP);
  assign imem_req    = waiting;
`ifdef IF_ALIGN_CHECK_EN
  assign imem_addr = req_pc_q;
  assign id_adel_o = id_adel_q;
`else
  assign imem_addr = {req_pc_q[31:2], 2'b00};
  assign id_adel_o = 1'b0;
`endif
  assign id_pc           = id_pc_q;
  assign id_inst         = id_inst_q;
  assign fetch_timeout_o = timeout_q;

  // Fetch FSM: a started transaction always runs to its ack; flush only discards the data.
  always_comb begin
    state_d     = state_q;
    req_pc_d    = req_pc_q;
    hold_inst_d = hold_inst_q;
`ifdef IF_ALIGN_CHECK_EN
    adel_pend_d = adel_pend_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (ce_i && !flush) begin
          req_pc_d = pc_i;
`ifdef IF_ALIGN_CHECK_EN
          if (pc_i[1:0] != 2'b00) begin
            state_d     = S_HOLD;
            hold_inst_d = NOP_INST;
            adel_pend_d = 1'b1;
          end else begin
            state_d     = S_REQ;
            adel_pend_d = 1'b0;
          end
`else
          state_d = S_REQ;
`endif
        end
      end
      S_REQ: begin
        if (flush) begin
          state_d = imem_ack ? S_IDLE : S_DROP;
        end else if (imem_ack) begin
          if (stall[1]) begin
            state_d     = S_HOLD;
            hold_inst_d = imem_rdata;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        if (flush || !stall[1]) state_d = S_IDLE;
      end
      S_DROP: begin
        if (imem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // IF/ID register: flush/bubble take priority, otherwise load fetched word when released.
  always_comb begin
    id_pc_d   = id_pc_q;
    id_inst_d = id_inst_q;
`ifdef IF_ALIGN_CHECK_EN
    id_adel_d = id_adel_q;
`endif
    if (flush || (stall[1] && !stall[2]) || (!stall[1] && !data_avail)) begin
      // Unreleased-without-data only happens with ce_i low; treat it as a bubble.
      id_pc_d   = 32'h0;
      id_inst_d = NOP_INST;
`ifdef IF_ALIGN_CHECK_EN
      id_adel_d = 1'b0;
`endif
    end else if (!stall[1]) begin
      id_pc_d   = req_pc_q;
      id_inst_d = (state_q == S_HOLD) ? hold_inst_q : imem_rdata;
`ifdef IF_ALIGN_CHECK_EN
      id_adel_d = (state_q == S_HOLD) ? adel_pend_q : 1'b0;
`endif
    end
  end

  // Timeout watchdog: counts unacked request cycles, flag is sticky until reset.
  always_comb begin
    to_cnt_d  = 8'h00;
    timeout_d = timeout_q;
    if (waiting && !imem_ack) begin
      to_cnt_d  = (to_cnt_q == 8'hFF) ? to_cnt_q : to_cnt_q + 8'h01;
      timeout_d = timeout_q || (to_cnt_d >= TO_LIM);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_pc_q    <= 32'h0;
      hold_inst_q <= NOP_INST;
      id_pc_q     <= 32'h0;
      id_inst_q   <= NOP_INST;
      to_cnt_q    <= 8'h00;
      timeout_q   <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
      adel_pend_q <= 1'b0;
      id_adel_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      req_pc_q    <= req_pc_d;
      hold_inst_q <= hold_inst_d;
      id_pc_q     <= id_pc_d;
      id_inst_q   <= id_inst_d;
      to_cnt_q    <= to_cnt_d;
      timeout_q   <= timeout_d;
`ifdef IF_ALIGN_CHECK_EN
      adel_pend_q <= adel_pend_d;
      id_adel_q   <= id_adel_d;
`endif
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: randomized fetch transactions against a scoreboard of delivered instructions.
// The stimulus side plays pc_reg, ctrl and instruction memory; a monitor checks the IF/ID register.
// Each delivery is checked for pc, word, adel flag and the cycle on which it lands.
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic        ce_i;
  logic [5:0]  stall;
  logic [5:0]  stall_ext;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_adel_o;
  logic        stallreq_if;
  logic        fetch_timeout_o;

  // ctrl: a fetch stall request freezes pc_reg and IF/ID.
  assign stall = stall_ext | (stallreq_if ? 6'b000011 : 6'b000000);

  inst_fetch #(.NOP_INST(NOP), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .ce_i(ce_i), .stall(stall), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .id_pc(id_pc), .id_inst(id_inst),
    .id_adel_o(id_adel_o), .stallreq_if(stallreq_if),
    .fetch_timeout_o(fetch_timeout_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int unsigned seq = 1;
  logic [31:0] last_word;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] w, input logic a, input int c);
    exp_t e;
    e.pc = p; e.inst = w; e.adel = a; e.cyc = c;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] exp_addr(input logic [31:0] p);
`ifdef IF_ALIGN_CHECK_EN
    return p;
`else
    return {p[31:2], 2'b00};
`endif
  endfunction

  function automatic logic [31:0] new_word();
    logic [7:0] top;
    top = 8'($urandom_range(1, 255));
    seq++;
    return {top, seq[23:0]};
  endfunction

  // Monitor: every change of IF/ID to a non-bubble value must be the next expected delivery.
  initial begin : monitor
    logic [64:0] prev;
    logic        bub;
    exp_t        e;
    prev = {32'h0, NOP, 1'b0};
    bub  = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (bub) begin
        chk("bubble_inst", id_inst, NOP);
        chk("bubble_pc", id_pc, 32'h0);
      end else if ((id_inst != NOP || id_adel_o) && ({id_pc, id_inst, id_adel_o} != prev)) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_load: got pc %h inst %h with nothing outstanding", id_pc, id_inst);
        end else begin
          e = sb.pop_front();
          chk("id_pc", id_pc, e.pc);
          chk("id_inst", id_inst, e.inst);
          chk("id_adel", {31'h0, id_adel_o}, {31'h0, e.adel});
          chk("load_cycle", cyc, e.cyc);
        end
      end
      prev = {id_pc, id_inst, id_adel_o};
      bub  = rst | flush | (stall[1] & ~stall[2]);
    end
  end

  // One fetch as pc_reg/ctrl/memory see it. Called on the negedge after the previous
  // consuming edge. fl: 0 none, 1 flush in 2nd REQ cycle (lat>=2), 2 flush with ack.
  task automatic fetch(input logic [31:0] p, input int lat, input int hold, input int fl);
    int          w;
    bit          got;
    bit          flushed;
    logic [31:0] word;
    pc_i = p;
    ce_i = 1'b1;
    got  = 0;
    w    = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      w++;
      if (imem_req) got = 1;
    end
    chk("req_seen", {31'h0, got}, 32'h1);
    if (!got) return;
    chk("req_latency", w, 1);
    chk("imem_addr", imem_addr, exp_addr(p));
    flushed = 0;
    for (int i = 0; i < lat; i++) begin
      if (fl == 1 && i == 1) flush = 1'b1;
      #1;
      chk("wait_stallreq", {31'h0, stallreq_if}, 32'h1);
      chk("wait_req", {31'h0, imem_req}, 32'h1);
      chk("wait_addr", imem_addr, exp_addr(p));
      @(negedge clk);
      if (flush) flushed = 1;
      flush = 1'b0;
    end
    word = flushed ? 32'hDEAD_BEEF : new_word();
    imem_ack   = 1'b1;
    imem_rdata = word;
    if (fl == 2) flush = 1'b1;
    if (hold > 0) stall_ext = 6'b001111;
    #1;
    chk("ack_stallreq", {31'h0, stallreq_if}, flushed ? 32'h1 : 32'h0);
    if (!flushed && fl != 2 && hold == 0) begin
      push(p, word, 1'b0, cyc + 1);
      last_word = word;
    end
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    flush      = 1'b0;
    chk("req_dropped", {31'h0, imem_req}, 32'h0);
    if (hold > 0) begin
      #1;
      chk("hold_stallreq", {31'h0, stallreq_if}, 32'h0);
      for (int i = 1; i < hold; i++) @(negedge clk);
      stall_ext = 6'b000000;
      push(p, word, 1'b0, cyc + 1);
      last_word = word;
      @(negedge clk);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] pc;
    logic [31:0] r;
    int          m, lat, hold, fl;
    rst = 1'b1; ce_i = 1'b0; pc_i = 32'h0; stall_ext = 6'b0; flush = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0; last_word = NOP;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_inst", id_inst, NOP);
    chk("rst_adel", {31'h0, id_adel_o}, 32'h0);
    chk("rst_timeout", {31'h0, fetch_timeout_o}, 32'h0);
    chk("rst_stallreq", {31'h0, stallreq_if}, 32'h0);
    rst = 1'b0;

    // Zero-wait stream, then wait states, then a held word.
    fetch(32'h0, 0, 0, 0);
    fetch(32'h4, 0, 0, 0);
    fetch(32'h8, 0, 0, 0);
    fetch(32'h100, 3, 0, 0);
    fetch(32'h104, 1, 2, 0);

    // ID hold (stall[2]) keeps the word; IF/ID-only stall inserts a bubble.
    ce_i = 1'b0;
    stall_ext = 6'b000110;
    repeat (2) @(negedge clk);
    chk("id_hold", id_inst, last_word);
    stall_ext = 6'b000010;
    @(negedge clk);
    chk("id_bubble", id_inst, NOP);
    stall_ext = 6'b000000;

    // Flush during the transaction, then flush coinciding with ack.
    fetch(32'h108, 3, 0, 1);
    fetch(32'h10C, 0, 0, 0);
    fetch(32'h110, 1, 0, 2);
    fetch(32'h114, 2, 0, 0);

`ifdef IF_ALIGN_CHECK_EN
    pc_i = 32'h102;
    ce_i = 1'b1;
    push(32'h102, NOP, 1'b1, cyc + 2);
    @(negedge clk);
    chk("misalign_noreq", {31'h0, imem_req}, 32'h0);
    @(negedge clk);
    chk("misalign_adel", {31'h0, id_adel_o}, 32'h1);
    chk("misalign_pc", id_pc, 32'h102);
`else
    fetch(32'h116, 0, 0, 0);
`endif

    // Randomized mix of latencies, holds and flushes.
    pc = 32'h1000;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        r = $urandom;
        r[1:0] = 2'b00;
        pc = r;
      end else begin
        pc = pc + 32'h4;
      end
      m    = $urandom_range(0, 9);
      fl   = (m == 0) ? 1 : ((m == 1) ? 2 : 0);
      lat  = (fl == 1) ? 3 : $urandom_range(0, 4);
      hold = (fl == 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      fetch(pc, lat, hold, fl);
    end

    // Timeout: flag sets after exactly 255 unacked cycles and survives the ack.
    pc_i = 32'h200;
    ce_i = 1'b1;
    @(negedge clk);
    chk("to_req", {31'h0, imem_req}, 32'h1);
    for (int k = 1; k <= 255; k++) begin
      @(negedge clk);
      if (k == 254) chk("to_before", {31'h0, fetch_timeout_o}, 32'h0);
      if (k == 255) chk("to_set", {31'h0, fetch_timeout_o}, 32'h1);
    end
    imem_ack   = 1'b1;
    imem_rdata = new_word();
    push(32'h200, imem_rdata, 1'b0, cyc + 1);
    @(negedge clk);
    imem_ack = 1'b0;
    ce_i     = 1'b0;
    @(negedge clk);
    chk("to_sticky", {31'h0, fetch_timeout_o}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("to_cleared", {31'h0, fetch_timeout_o}, 32'h0);

    // Reset in the middle of a request abandons it.
    pc_i = 32'h300;
    ce_i = 1'b1;
    @(negedge clk);
    chk("mid_req", {31'h0, imem_req}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    rst = 1'b0;
    fetch(32'h400, 1, 0, 0);

    ce_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
